// File: rtl/hazard_ctrl_if.sv
// Control/status bundle between the pipeline datapath and the hazard sequencer.
// The slave side is the sequencer; the master side is the datapath (or a bench).
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic             ex_memread_i;
    logic             ex_regwrite_i;
    logic [3:0]       ex_rd_i;
    logic [3:0]       id_rs_i;
    logic [3:0]       id_rt_i;
    logic             id_use_rs_i;
    logic             id_use_rt_i;
    logic             id_br_taken_i;
    logic             id_halt_i;
    logic             imem_busy_i;
    logic             dmem_busy_i;
    logic             clr_cnt_i;
    logic             pc_wen_o;
    logic             ifid_nop_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             pipe_freeze_o;
    logic             halted_o;
    logic             wd_err_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport slave (
        input  ex_memread_i, ex_regwrite_i, ex_rd_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_br_taken_i, id_halt_i, imem_busy_i, dmem_busy_i, clr_cnt_i,
        output pc_wen_o, ifid_nop_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, halted_o,
               wd_err_o, stall_cnt_o, flush_cnt_o
    );

    modport master (
        output ex_memread_i, ex_regwrite_i, ex_rd_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_br_taken_i, id_halt_i, imem_busy_i, dmem_busy_i, clr_cnt_i,
        input  pc_wen_o, ifid_nop_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, halted_o,
               wd_err_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard sequencer: load-use stall, branch redirect, memory freeze, HLT drain,
// saturating stall/flush counters and a dmem-wait watchdog.
module hazard_ctrl_unit #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3,
    parameter int WD_LIMIT  = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    hazard_ctrl_if.slave  hif
);
    localparam int DW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC);
    localparam int WW = $clog2(WD_LIMIT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [WW-1:0] WD_LIM     = WW'(WD_LIMIT);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

    state_e           state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [WW-1:0]    wd_q, wd_d;
    logic             wd_err_q, wd_err_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

    logic lu, br_flush, busy;

    assign busy = hif.dmem_busy_i;
    assign lu   = hif.ex_memread_i & hif.ex_regwrite_i & (hif.ex_rd_i != 4'd0) &
                  ((hif.id_use_rs_i & (hif.id_rs_i == hif.ex_rd_i)) |
                   (hif.id_use_rt_i & (hif.id_rt_i == hif.ex_rd_i)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            drain_q  <= '0;
            wd_q     <= '0;
            wd_err_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            wd_q     <= wd_d;
            wd_err_q <= wd_err_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            RUN: if (!busy && !hif.id_br_taken_i && !lu && hif.id_halt_i) begin
                state_d = DRAIN;
                drain_d = '0;
            end
            DRAIN: if (!busy) begin
                // Each unfrozen cycle moves the last instructions one stage closer to WB.
                if (drain_q == DRAIN_LAST) begin
                    state_d = HALTED;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = HALTED;
        endcase

        stall_d = stall_q;
        flush_d = flush_q;
        if (state_q == RUN) begin
            if (!hif.pc_wen_o && stall_q != '1) stall_d = stall_q + 1'b1;
            if (br_flush && flush_q != '1)      flush_d = flush_q + 1'b1;
        end
        if (hif.clr_cnt_i) begin
            stall_d = '0;
            flush_d = '0;
        end

        wd_d     = busy ? ((wd_q == WD_LIM) ? wd_q : wd_q + 1'b1) : '0;
        wd_err_d = wd_err_q | (wd_d == WD_LIM);
    end

    always_comb begin
        hif.pc_wen_o      = 1'b0;
        hif.ifid_nop_o    = 1'b0;
        hif.ifid_flush_o  = 1'b0;
        hif.idex_bubble_o = 1'b0;
        hif.pipe_freeze_o = 1'b0;
        hif.halted_o      = 1'b0;
        br_flush          = 1'b0;
        case (state_q)
            RUN: begin
                if (busy) begin
                    hif.pipe_freeze_o = 1'b1;
                end else if (hif.id_br_taken_i && hif.imem_busy_i) begin
                    hif.ifid_nop_o    = 1'b1;
                    hif.idex_bubble_o = 1'b1;
                end else if (hif.id_br_taken_i) begin
                    hif.pc_wen_o     = 1'b1;
                    hif.ifid_flush_o = 1'b1;
                    br_flush         = 1'b1;
                end else if (lu) begin
                    hif.ifid_nop_o    = 1'b1;
                    hif.idex_bubble_o = 1'b1;
                end else if (hif.id_halt_i || hif.imem_busy_i) begin
                    hif.ifid_flush_o = 1'b1;
                end else begin
                    hif.pc_wen_o = 1'b1;
                end
            end
            DRAIN: begin
                hif.ifid_flush_o  = 1'b1;
                hif.pipe_freeze_o = busy;
            end
            default: begin
                hif.halted_o      = 1'b1;
                hif.ifid_flush_o  = 1'b1;
                hif.idex_bubble_o = 1'b1;
            end
        endcase
    end

    assign hif.wd_err_o    = wd_err_q;
    assign hif.stall_cnt_o = stall_q;
    assign hif.flush_cnt_o = flush_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized + directed bench for hazard_ctrl_unit against a rule-level reference model.
module tb_hazard_ctrl_unit;
    localparam int CNT_W = 4, DRAIN_CYC = 3, WD_LIMIT = 4;
    localparam int CMAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       memread, regwrite;
        logic [3:0] rd, rs, rt;
        logic       use_rs, use_rt, br, halt, imem, dmem, clr;
    } in_t;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();
    hazard_ctrl_unit #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC), .WD_LIMIT(WD_LIMIT))
        dut (.clk(clk), .rst_n(rst_n), .hif(hif));

    int n_chk = 0, n_pass = 0;
    // Reference state: 0 = running, 1 = draining, 2 = halted.
    int m_st, m_drain, m_wd, m_stall, m_flush;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic drive(input in_t v);
        hif.ex_memread_i  = v.memread;  hif.ex_regwrite_i = v.regwrite;
        hif.ex_rd_i       = v.rd;       hif.id_rs_i       = v.rs;
        hif.id_rt_i       = v.rt;       hif.id_use_rs_i   = v.use_rs;
        hif.id_use_rt_i   = v.use_rt;   hif.id_br_taken_i = v.br;
        hif.id_halt_i     = v.halt;     hif.imem_busy_i   = v.imem;
        hif.dmem_busy_i   = v.dmem;     hif.clr_cnt_i     = v.clr;
    endtask

    function automatic bit load_use(input in_t v);
        return v.memread && v.regwrite && v.rd != 0 &&
               ((v.use_rs && v.rs == v.rd) || (v.use_rt && v.rt == v.rd));
    endfunction

    // Expected {pc_wen, ifid_nop, ifid_flush, idex_bubble, pipe_freeze, halted, wd_err}
    function automatic logic [6:0] exp_outs(input in_t v);
        logic [6:0] o;
        if (m_st == 2)           o = 7'b0011010;
        else if (m_st == 1)      o = v.dmem ? 7'b0010100 : 7'b0010000;
        else if (v.dmem)         o = 7'b0000100;
        else if (v.br && v.imem) o = 7'b0101000;
        else if (v.br)           o = 7'b1010000;
        else if (load_use(v))    o = 7'b0101000;
        else if (v.halt)         o = 7'b0010000;
        else if (v.imem)         o = 7'b0010000;
        else                     o = 7'b1000000;
        o[0] = m_err;
        return o;
    endfunction

    task automatic model_step(input in_t v);
        logic [6:0] o;
        o = exp_outs(v);
        if (m_st == 0) begin
            if (!o[6]) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
            if (!v.dmem && v.br && !v.imem) m_flush = (m_flush == CMAX) ? CMAX : m_flush + 1;
            if (!v.dmem && !v.br && !load_use(v) && v.halt) begin m_st = 1; m_drain = 0; end
        end else if (m_st == 1 && !v.dmem) begin
            m_drain++;
            if (m_drain == DRAIN_CYC) m_st = 2;
        end
        if (v.clr) begin m_stall = 0; m_flush = 0; end
        if (v.dmem) begin
            m_wd = (m_wd == WD_LIMIT) ? WD_LIMIT : m_wd + 1;
            if (m_wd == WD_LIMIT) m_err = 1'b1;
        end else m_wd = 0;
    endtask

    task automatic check_all(input in_t v);
        chk("outs", {hif.pc_wen_o, hif.ifid_nop_o, hif.ifid_flush_o, hif.idex_bubble_o,
                     hif.pipe_freeze_o, hif.halted_o, hif.wd_err_o}, 32'(exp_outs(v)));
        chk("stall_cnt", 32'(hif.stall_cnt_o), 32'(m_stall));
        chk("flush_cnt", 32'(hif.flush_cnt_o), 32'(m_flush));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cyc(input in_t v);
        drive(v);
        #1 check_all(v);
        @(posedge clk);
        model_step(v);
        @(negedge clk);
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        drive(z);
        rst_n = 1'b0;
        m_st = 0; m_drain = 0; m_wd = 0; m_stall = 0; m_flush = 0; m_err = 1'b0;
        #1 check_all(z);
        chk("rst_pc_wen", 32'(hif.pc_wen_o), 32'd1);
        rst_n = 1'b1;
    endtask

    in_t v, lu_v;

    initial begin
        drive('0);
        @(negedge clk);
        do_reset();

        // Load-use: one stall cycle, then normal.
        lu_v = '0; lu_v.memread = 1; lu_v.regwrite = 1; lu_v.rd = 4'd3; lu_v.rs = 4'd3; lu_v.use_rs = 1;
        cyc(lu_v);
        v = '0; cyc(v);
        chk("lu_stall_cnt", 32'(hif.stall_cnt_o), 32'd1);
        v = lu_v; v.rd = 4'd0; v.rs = 4'd0;
        drive(v);
        #1 chk("rd0_no_stall", 32'(hif.pc_wen_o), 32'd1);
        cyc(v);

        // Branch waiting on fetch, then redirect.
        v = '0; v.br = 1; v.imem = 1;
        cyc(v); cyc(v);
        v.imem = 0;
        drive(v);
        #1 chk("br_flush", {30'd0, hif.ifid_flush_o, hif.pc_wen_o}, 32'd3);
        cyc(v);
        chk("br_flush_cnt", 32'(hif.flush_cnt_o), 32'd1);

        // Freeze dominates branch and load-use.
        do_reset();
        v = lu_v; v.br = 1; v.dmem = 1;
        for (int i = 0; i < 3; i++) cyc(v);
        v.dmem = 0; cyc('0);
        v = lu_v; v.br = 1; v.dmem = 1;
        cyc(v); cyc(v);
        chk("frz_stall_cnt", 32'(hif.stall_cnt_o), 32'd5);
        chk("frz_flush_cnt", 32'(hif.flush_cnt_o), 32'd0);

        // HLT drain with a frozen cycle, then halted until reset.
        do_reset();
        v = '0; v.halt = 1; cyc(v);
        v = '0; cyc(v);
        v.dmem = 1; cyc(v);
        v.dmem = 0; cyc(v);
        chk("pre_halted", 32'(hif.halted_o), 32'd0);
        cyc(v);
        for (int i = 0; i < 3; i++) cyc(v);
        chk("halted_sticky", 32'(hif.halted_o), 32'd1);

        // Reset mid-drain.
        do_reset();
        v = '0; v.halt = 1; cyc(v);
        v = '0; cyc(v);
        do_reset();
        cyc(v);

        // Watchdog, counter saturation and clear.
        v = '0; v.dmem = 1;
        for (int i = 0; i < 4; i++) cyc(v);
        chk("wd_err_set", 32'(hif.wd_err_o), 32'd1);
        for (int i = 0; i < 14; i++) cyc(v);
        v = '0; cyc(v);
        chk("wd_err_sticky", 32'(hif.wd_err_o), 32'd1);
        chk("stall_sat", 32'(hif.stall_cnt_o), 32'(CMAX));
        v.clr = 1; cyc(v);
        chk("clr_cnt", 32'(hif.stall_cnt_o), 32'd0);

        // Randomized run with periodic resets.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (i % 90 == 89) do_reset();
            v.memread  = ($urandom_range(0, 1) == 1);
            v.regwrite = ($urandom_range(0, 3) != 0);
            v.rd       = 4'($urandom_range(0, 3));
            v.rs       = 4'($urandom_range(0, 3));
            v.rt       = 4'($urandom_range(0, 3));
            v.use_rs   = ($urandom_range(0, 1) == 1);
            v.use_rt   = ($urandom_range(0, 1) == 1);
            v.br       = ($urandom_range(0, 4) == 0);
            v.halt     = ($urandom_range(0, 24) == 0);
            v.imem     = ($urandom_range(0, 3) == 0);
            v.dmem     = (i % 50 > 44) || ($urandom_range(0, 5) == 0);
            v.clr      = (m_st == 0) && ($urandom_range(0, 29) == 0);
            cyc(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
